cells_update_engine: RTL



---
 rtl/cells_pkg.sv | 39 +++
 rtl/cell_scan_counter.sv | 48 ++++
 rtl/cells_update_engine.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cells_pkg.sv
// cells_pkg: cell codes, engine states and the neighbour-candidate ordering
// shared by the falling-sand update engine.
package cells_pkg;

    typedef enum logic [1:0] {EMPTY = 2'd0, SAND = 2'd1, WATER = 2'd2, STONE = 2'd3} cell_t;
    typedef enum logic [1:0] {IDLE, BASE, PROBE, DONE} state_e;
    typedef enum logic [2:0] {DOWN, DOWN_L, DOWN_R, LEFT, RIGHT} cand_e;

    localparam int SAND_CANDS  = 3;
    localparam int WATER_CANDS = 5;

    // Slot order is down, down-first, down-second, first, second; dir picks the first side.
    function automatic cand_e slot_cand(input logic [2:0] slot, input logic dir);
        return slot == 3'd0 ? DOWN :
               slot == 3'd1 ? (dir ? DOWN_R : DOWN_L) :
               slot == 3'd2 ? (dir ? DOWN_L : DOWN_R) :
               slot == 3'd3 ? (dir ? RIGHT : LEFT) :
                              (dir ? LEFT : RIGHT);
    endfunction

    function automatic logic skipped(input cand_e c, input logic bottom, input logic left, input logic right);
        return (bottom && (c == DOWN || c == DOWN_L || c == DOWN_R)) ||
               (left && (c == DOWN_L || c == LEFT)) ||
               (right && (c == DOWN_R || c == RIGHT));
    endfunction

    // Lowest slot in [from, limit) that is not cut off by an edge; limit means none left.
    function automatic logic [2:0] first_live_slot(input logic [2:0] from, input logic [2:0] limit,
                                                   input logic dir, input logic bottom,
                                                   input logic left, input logic right);
        logic [2:0] r;
        r = limit;
        for (int i = 4; i >= 0; i--)
            if (3'(i) >= from && 3'(i) < limit && !skipped(slot_cand(3'(i), dir), bottom, left, right))
                r = 3'(i);
        return r;
    endfunction

endpackage

// File: rtl/cell_scan_counter.sv
// cell_scan_counter: row, column and linear address counters that walk the
// grid in raster order, with edge flags for the current cell.
module cell_scan_counter #(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS)
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  clear,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last_cell,
    output logic                  at_bottom,
    output logic                  at_left_edge,
    output logic                  at_right_edge
);
    localparam int COL_W = $clog2(ACTIVE_COLUMNS);
    localparam int ROW_W = $clog2(ACTIVE_ROWS);

    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    assign at_left_edge  = col_q == '0;
    assign at_right_edge = col_q == COL_W'(ACTIVE_COLUMNS - 1);
    assign at_bottom     = row_q == ROW_W'(ACTIVE_ROWS - 1);
    assign last_cell     = at_bottom && at_right_edge;
    assign addr          = addr_q;

    always_comb begin
        col_d  = clear ? '0 : step ? (at_right_edge ? '0 : col_q + 1'b1) : col_q;
        row_d  = clear ? '0 : (step && at_right_edge) ? row_q + 1'b1 : row_q;
        addr_d = clear ? '0 : step ? addr_q + 1'b1 : addr_q;
    end

    always_ff @(posedge clk_i or negedge reset_ni)
        if (!reset_ni) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end

endmodule

// File: rtl/cells_update_engine.sv
// cells_update_engine: one raster pass per frame moving sand/water cells from
// the current frame (VRAM) into the next frame (RAM) with per-material rules.
module cells_update_engine
    import cells_pkg::*;
#(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] vram_rd_address_o,
    input  logic [DATA_WIDTH-1:0] vram_rd_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_address_o,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [ADDR_WIDTH-1:0] vram_wr_address_o,
    output logic [DATA_WIDTH-1:0] vram_wr_data_o,
    output logic                  vram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] ram_wr_address_o,
    output logic [DATA_WIDTH-1:0] ram_wr_data_o,
    output logic                  ram_wr_en_o
);
    state_e                state_q, state_d;
    logic [2:0]            cand_q, cand_d;
    cell_t                 code_q, code_d;
    logic                  dir_q, dir_d;
    logic                  clear, resolve, last_cell, at_bottom, at_left, at_right, occupied;
    logic [ADDR_WIDTH-1:0] base, rd_addr, probe_addr, hit_addr;
    logic [2:0]            limit, next_slot;
    cell_t                 cur;

    cell_scan_counter #(
        .ACTIVE_COLUMNS(ACTIVE_COLUMNS),
        .ACTIVE_ROWS   (ACTIVE_ROWS),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_scan (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .clear        (clear),
        .step         (resolve),
        .addr         (base),
        .last_cell    (last_cell),
        .at_bottom    (at_bottom),
        .at_left_edge (at_left),
        .at_right_edge(at_right)
    );

    function automatic logic [ADDR_WIDTH-1:0] neighbour(input cand_e c, input logic [ADDR_WIDTH-1:0] b);
        logic [ADDR_WIDTH-1:0] below;
        below = b + ADDR_WIDTH'(ACTIVE_COLUMNS);
        return c == DOWN ? below : c == DOWN_L ? below - 1'b1 : c == DOWN_R ? below + 1'b1 :
               c == LEFT ? b - 1'b1 : b + 1'b1;
    endfunction

    // In BASE the code arrives straight from VRAM; while probing it comes from the latch.
    assign cur        = state_q == PROBE ? code_q : cell_t'(vram_rd_data[1:0]);
    assign limit      = cur == SAND ? 3'(SAND_CANDS) : cur == WATER ? 3'(WATER_CANDS) : 3'd0;
    assign next_slot  = first_live_slot(state_q == PROBE ? cand_q + 3'd1 : 3'd0, limit, dir_q,
                                        at_bottom, at_left, at_right);
    assign probe_addr = neighbour(slot_cand(next_slot, dir_q), base);
    assign hit_addr   = neighbour(slot_cand(cand_q, dir_q), base);
    assign occupied   = vram_rd_data != '0 || ram_rd_data != '0;
    assign busy_o            = state_q != IDLE;
    assign vram_rd_address_o = rd_addr;
    assign ram_rd_address_o  = rd_addr;

    always_comb begin
        state_d           = state_q;
        cand_d            = cand_q;
        code_d            = code_q;
        dir_d             = dir_q;
        clear             = 1'b0;
        resolve           = 1'b0;
        done_o            = 1'b0;
        rd_addr           = '0;
        vram_wr_en_o      = 1'b0;
        vram_wr_address_o = '0;
        vram_wr_data_o    = '0;
        ram_wr_en_o       = 1'b0;
        ram_wr_address_o  = '0;
        ram_wr_data_o     = '0;
        case (state_q)
            IDLE: if (start_i) begin
                clear   = 1'b1;
                state_d = BASE;
            end
            BASE, PROBE: begin
                if (state_q == PROBE && !occupied) begin
                    resolve           = 1'b1;
                    vram_wr_en_o      = 1'b1;
                    vram_wr_address_o = base;
                    ram_wr_en_o       = 1'b1;
                    ram_wr_address_o  = hit_addr;
                    ram_wr_data_o     = DATA_WIDTH'(cur);
                end else if (next_slot == limit) begin
                    resolve          = 1'b1;
                    ram_wr_en_o      = cur != EMPTY;
                    ram_wr_address_o = base;
                    ram_wr_data_o    = DATA_WIDTH'(cur);
                end else begin
                    cand_d  = next_slot;
                    code_d  = cur;
                    rd_addr = probe_addr;
                    state_d = PROBE;
                end
                if (resolve) begin
                    rd_addr = base + 1'b1;
                    state_d = last_cell ? DONE : BASE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                dir_d   = ~dir_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni)
        if (!reset_ni) begin
            state_q <= IDLE;
            cand_q  <= '0;
            code_q  <= EMPTY;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            dir_q   <= dir_d;
        end

endmodule
